csr_sequencer: RTL and testbench
================================

# csr_sequencer

Initiator-side controller for the machine-level CSR unit. Accepts SYSTEM-class requests from the core pipeline: CSR access, MRET, and synchronous trap. It converts each request into the CSR unit's single-cycle op protocol and waits out the unit's one-cycle registered result. An illegal CSR access is converted into an illegal-instruction trap. The sequencer then returns either the old CSR value or a redirect PC to the pipeline over a valid/ready response channel.

## Interface
Parameters:
- None; widths are fixed by the CSR unit (XLEN 32, CSR address 12).

Ports:
- clk  in  1  clock; synchronous reset, active-high, is `reset`
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid
- req_kind  in  2  00=CSR access, 01=MRET, 10=trap, 11=reserved (treated as trap)
- req_csr_op  in  2  01=RW, 10=RS, 11=RC, 00=illegal
- req_addr  in  12  CSR address
- req_wdata  in  32  CSR write operand
- req_pc  in  32  PC of requesting instruction
- req_cause  in  5  trap cause; bit 4 is the interrupt flag, bits 3:0 are the code
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_redirect  out  1  1 = rsp_data is the next PC
- rsp_trapped  out  1  request was converted to an illegal-instruction trap
- rsp_data  out  32  old CSR value or target PC
- csr_op  out  3  to CSR unit: 000 exception, 001 MRET, 101 RW, 110 RS, 111 RC, 100 idle
- csr_addr  out  12  to CSR unit: address or exception value
- csr_wdata  out  32  to CSR unit: write value or exception PC
- csr_rdata  in  32  from CSR unit (registered there)
- csr_fault  in  1  from CSR unit (registered there)

## Operation
- Idle op is 3'b100. It is the only value driven when not issuing. It alters no CSR state.
- States: IDLE, ISSUE, WAIT, TRAP_ISSUE, TRAP_WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On handshake, capture all req_* fields.
  - CSR kind with req_csr_op≠00 → ISSUE.
  - CSR kind with req_csr_op=00 → TRAP_ISSUE with cause 5'd2.
  - MRET → ISSUE.
  - Trap or reserved kind → TRAP_ISSUE with the captured cause.
- ISSUE:
  - Drive csr_op = {1, req_csr_op} for CSR, or 001 for MRET.
  - Drive csr_addr = req_addr and csr_wdata = req_wdata.
  - Next state WAIT.
- WAIT: sample csr_rdata and csr_fault.
  - fault=1 on a CSR access → TRAP_ISSUE with cause 5'd2; mark trapped.
  - CSR access without fault: rsp_data = csr_rdata, redirect=0.
  - MRET: rsp_data = csr_rdata (mepc), redirect=1.
  - Either no-fault case → RESP.
- TRAP_ISSUE:
  - Drive csr_op=000, csr_addr = {7'b0, cause}, csr_wdata = req_pc.
  - Next state TRAP_WAIT.
- TRAP_WAIT:
  - rsp_data = csr_rdata (mtvec base), redirect=1.
  - rsp_trapped=1 only for the converted illegal access.
  - csr_fault is ignored.
  - Next state RESP.
- RESP:
  - rsp_valid=1; all rsp_* held stable until rsp_ready.
  - Transfer → IDLE.
  - req_ready=0 throughout.
- csr_op, csr_addr, csr_wdata and all rsp_* are registered outputs.
- Reset values:
  - State IDLE.
  - csr_op=100.
  - csr_addr=0, csr_wdata=0.
  - rsp_valid=0, rsp_redirect=0, rsp_trapped=0, rsp_data=0.
  - req_ready=1 (combinational from state).

## Timing
- Handshake at edge 0 → csr_op valid cycle 1 → result sampled cycle 2 → rsp_valid cycle 3 (3-cycle latency).
- Illegal-address fault path: trap issued cycle 3, sampled cycle 4, rsp_valid cycle 5.
- req_csr_op=00 skips the probe: trap issued cycle 1, rsp_valid cycle 3.
- rsp_ready held low: remains in RESP indefinitely; no new request accepted.
- One request in flight maximum; no pipelining.
- Reset asserted mid-sequence:
  - Returns to IDLE next edge and drops rsp_valid.
  - Drives idle op; any partially issued op is abandoned.
  - The CSR unit shares the reset.

## Configuration
- CSR_SEQ_IRQ_EN: adds inputs irq_req (1) and irq_pc (32), and output rsp_irq (1).
- In IDLE, irq_req has priority over req_valid; req_ready=0 that cycle.
- Probe step:
  - Issue RS to 12'h300 with wdata 0.
  - Sample bit 3 (MIE).
- MIE=1:
  - Issue exception with csr_addr = 12'h01B and csr_wdata = irq_pc.
  - Respond redirect=1, rsp_irq=1.
- MIE=0: return to IDLE with no response.
- Without the macro: ports absent; FSM has no IRQ_PROBE or IRQ_WAIT states.

## Structure
- Shared package csr_pkg holds:
  - CSR op encodings, including CSR_OP_IDLE = 3'b100.
  - CSR address constants (300, 304, 305, 341, 342, 344).
  - Cause constants (CAUSE_ILLEGAL_INSN = 5'd2, CAUSE_M_EXT_IRQ = 5'h1B).
  - The req_kind typedef and the FSM state enum.
- Single module; no sub-module warranted.

## Test plan
- mtvec programming and illegal trap:
  - CSRRW 305 with wdata 32'h0000_0100 → rsp_data 0, redirect 0, at cycle 3.
  - Then a trap with cause 5'd11 at pc 32'h40 → rsp_data 32'h100, redirect 1.
- CSRRS 300 with wdata 32'h8 after reset → rsp_data 0.
- Repeat with wdata 0 → rsp_data 32'h8.
- Trap at pc 32'h1234 then MRET → MRET rsp_data 32'h1234, redirect 1.
- CSRRW to address 12'h7C0 with mtvec=32'h200:
  - rsp_trapped 1, rsp_data 32'h200, at cycle 5.
  - A following CSRRS 342 with wdata 0 returns 32'h2.
- rsp_ready held low 10 cycles:
  - rsp_valid and rsp_data stable; req_ready 0.
  - Reset mid-WAIT → rsp_valid 0, csr_op 100 next cycle.
- With CSR_SEQ_IRQ_EN:
  - irq_req with MIE=0 → no response.
  - After CSRRS 300 with wdata 8, irq_req with irq_pc 32'h80 → redirect to mtvec, rsp_irq 1.
  - mcause then reads 32'h8000_000B.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-level CSR unit and its request sequencer.
// Defining CSR_SEQ_IRQ_EN adds the interrupt-probe states to the sequencer state enum.
package csr_pkg;

    localparam int XLEN   = 32;
    localparam int CSR_AW = 12;

    localparam logic [2:0] CSR_OP_EXC  = 3'b000;
    localparam logic [2:0] CSR_OP_MRET = 3'b001;
    localparam logic [2:0] CSR_OP_IDLE = 3'b100;
    localparam logic [2:0] CSR_OP_RW   = 3'b101;
    localparam logic [2:0] CSR_OP_RS   = 3'b110;
    localparam logic [2:0] CSR_OP_RC   = 3'b111;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam logic [4:0] CAUSE_ILLEGAL_INSN = 5'd2;
    localparam logic [4:0] CAUSE_M_EXT_IRQ    = 5'h1B;

    localparam int MSTATUS_MIE_BIT = 3;

    typedef enum logic [1:0] {
        REQ_CSR  = 2'b00,
        REQ_MRET = 2'b01,
        REQ_TRAP = 2'b10,
        REQ_RSVD = 2'b11
    } req_kind_e;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE      = 3'd1,
        ST_WAIT       = 3'd2,
        ST_TRAP_ISSUE = 3'd3,
        ST_TRAP_WAIT  = 3'd4,
`ifdef CSR_SEQ_IRQ_EN
        ST_RESP       = 3'd5,
        ST_IRQ_PROBE  = 3'd6,
        ST_IRQ_WAIT   = 3'd7
`else
        ST_RESP       = 3'd5
`endif
    } seq_state_e;

    // MRET carries its own opcode; CSR accesses map 01/10/11 onto RW/RS/RC.
    function automatic logic [2:0] csr_issue_op(input req_kind_e kind, input logic [1:0] op);
        return (kind == REQ_MRET) ? CSR_OP_MRET : {1'b1, op};
    endfunction

    function automatic logic [CSR_AW-1:0] trap_xval(input logic [4:0] cause);
        return {7'b0, cause};
    endfunction

endpackage

// File: rtl/csr_sequencer.sv
// Converts SYSTEM-class pipeline requests into CSR-unit ops and returns old value or redirect PC.
// Optional CSR_SEQ_IRQ_EN adds an external-interrupt entry path (irq_req/irq_pc/rsp_irq).
//
// state        | meaning
// IDLE         | ready for a request (or interrupt when enabled)
// ISSUE        | CSR access / MRET op on csr_op this cycle
// WAIT         | CSR unit result valid; sample rdata and fault
// TRAP_ISSUE   | exception op on csr_op this cycle
// TRAP_WAIT    | mtvec base valid on csr_rdata; sample it
// RESP         | response held until rsp_ready
// IRQ_PROBE    | RS of mstatus with zero operand (read-only probe)
// IRQ_WAIT     | sample mstatus.MIE to decide whether to take the interrupt
module csr_sequencer
    import csr_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_kind,
    input  logic [1:0]        req_csr_op,
    input  logic [CSR_AW-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [XLEN-1:0]   req_pc,
    input  logic [4:0]        req_cause,
`ifdef CSR_SEQ_IRQ_EN
    input  logic              irq_req,
    input  logic [XLEN-1:0]   irq_pc,
    output logic              rsp_irq,
`endif
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_redirect,
    output logic              rsp_trapped,
    output logic [XLEN-1:0]   rsp_data,
    output logic [2:0]        csr_op,
    output logic [CSR_AW-1:0] csr_addr,
    output logic [XLEN-1:0]   csr_wdata,
    input  logic [XLEN-1:0]   csr_rdata,
    input  logic              csr_fault
);

    seq_state_e        state_q, state_d;
    req_kind_e         kind_q, kind_d;
    logic [1:0]        op_q, op_d;
    logic [CSR_AW-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [4:0]        cause_q, cause_d;
    logic              trapped_q, trapped_d;

    logic [2:0]        csr_op_q, csr_op_d;
    logic [CSR_AW-1:0] csr_addr_q, csr_addr_d;
    logic [XLEN-1:0]   csr_wdata_q, csr_wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_redirect_q, rsp_redirect_d;
    logic              rsp_trapped_q, rsp_trapped_d;
    logic [XLEN-1:0]   rsp_data_q, rsp_data_d;

`ifdef CSR_SEQ_IRQ_EN
    logic              irq_q, irq_d;
    logic              rsp_irq_q, rsp_irq_d;

    // A pending interrupt wins the IDLE cycle, so the pipeline request must wait.
    assign req_ready = (state_q == ST_IDLE) && !irq_req;
`else
    assign req_ready = (state_q == ST_IDLE);
`endif

    always_comb begin
        state_d        = state_q;
        kind_d         = kind_q;
        op_d           = op_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        pc_d           = pc_q;
        cause_d        = cause_q;
        trapped_d      = trapped_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_redirect_d = rsp_redirect_q;
        rsp_trapped_d  = rsp_trapped_q;
        rsp_data_d     = rsp_data_q;
`ifdef CSR_SEQ_IRQ_EN
        irq_d          = irq_q;
        rsp_irq_d      = rsp_irq_q;
`endif

        case (state_q)
            ST_IDLE: begin
`ifdef CSR_SEQ_IRQ_EN
                if (irq_req) begin
                    pc_d      = irq_pc;
                    cause_d   = CAUSE_M_EXT_IRQ;
                    trapped_d = 1'b0;
                    irq_d     = 1'b1;
                    state_d   = ST_IRQ_PROBE;
                end else
`endif
                if (req_valid) begin
                    kind_d    = req_kind_e'(req_kind);
                    op_d      = req_csr_op;
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    pc_d      = req_pc;
                    cause_d   = req_cause;
                    trapped_d = 1'b0;
`ifdef CSR_SEQ_IRQ_EN
                    irq_d     = 1'b0;
`endif
                    case (req_kind_e'(req_kind))
                        REQ_CSR: begin
                            if (req_csr_op != 2'b00) begin
                                state_d = ST_ISSUE;
                            end else begin
                                cause_d   = CAUSE_ILLEGAL_INSN;
                                trapped_d = 1'b1;
                                state_d   = ST_TRAP_ISSUE;
                            end
                        end
                        REQ_MRET: state_d = ST_ISSUE;
                        default:  state_d = ST_TRAP_ISSUE;
                    endcase
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if ((kind_q == REQ_CSR) && csr_fault) begin
                    cause_d   = CAUSE_ILLEGAL_INSN;
                    trapped_d = 1'b1;
                    state_d   = ST_TRAP_ISSUE;
                end else begin
                    rsp_valid_d    = 1'b1;
                    rsp_data_d     = csr_rdata;
                    rsp_redirect_d = (kind_q == REQ_MRET);
                    rsp_trapped_d  = 1'b0;
`ifdef CSR_SEQ_IRQ_EN
                    rsp_irq_d      = 1'b0;
`endif
                    state_d        = ST_RESP;
                end
            end
            ST_TRAP_ISSUE: state_d = ST_TRAP_WAIT;
            ST_TRAP_WAIT: begin
                rsp_valid_d    = 1'b1;
                rsp_data_d     = csr_rdata;
                rsp_redirect_d = 1'b1;
                rsp_trapped_d  = trapped_q;
`ifdef CSR_SEQ_IRQ_EN
                rsp_irq_d      = irq_q;
`endif
                state_d        = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
`ifdef CSR_SEQ_IRQ_EN
            ST_IRQ_PROBE: state_d = ST_IRQ_WAIT;
            ST_IRQ_WAIT: begin
                if (csr_rdata[MSTATUS_MIE_BIT]) state_d = ST_TRAP_ISSUE;
                else                            state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // Ops are registered on entry to an issue state so they appear for exactly that cycle.
        csr_op_d    = CSR_OP_IDLE;
        csr_addr_d  = csr_addr_q;
        csr_wdata_d = csr_wdata_q;
        case (state_d)
            ST_ISSUE: begin
                csr_op_d    = csr_issue_op(kind_d, op_d);
                csr_addr_d  = addr_d;
                csr_wdata_d = wdata_d;
            end
            ST_TRAP_ISSUE: begin
                csr_op_d    = CSR_OP_EXC;
                csr_addr_d  = trap_xval(cause_d);
                csr_wdata_d = pc_d;
            end
`ifdef CSR_SEQ_IRQ_EN
            ST_IRQ_PROBE: begin
                csr_op_d    = CSR_OP_RS;
                csr_addr_d  = CSR_MSTATUS;
                csr_wdata_d = '0;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            kind_q         <= REQ_CSR;
            op_q           <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            pc_q           <= '0;
            cause_q        <= '0;
            trapped_q      <= 1'b0;
            csr_op_q       <= CSR_OP_IDLE;
            csr_addr_q     <= '0;
            csr_wdata_q    <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_redirect_q <= 1'b0;
            rsp_trapped_q  <= 1'b0;
            rsp_data_q     <= '0;
`ifdef CSR_SEQ_IRQ_EN
            irq_q          <= 1'b0;
            rsp_irq_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            kind_q         <= kind_d;
            op_q           <= op_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            pc_q           <= pc_d;
            cause_q        <= cause_d;
            trapped_q      <= trapped_d;
            csr_op_q       <= csr_op_d;
            csr_addr_q     <= csr_addr_d;
            csr_wdata_q    <= csr_wdata_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_redirect_q <= rsp_redirect_d;
            rsp_trapped_q  <= rsp_trapped_d;
            rsp_data_q     <= rsp_data_d;
`ifdef CSR_SEQ_IRQ_EN
            irq_q          <= irq_d;
            rsp_irq_q      <= rsp_irq_d;
`endif
        end
    end

    assign csr_op       = csr_op_q;
    assign csr_addr     = csr_addr_q;
    assign csr_wdata    = csr_wdata_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_redirect = rsp_redirect_q;
    assign rsp_trapped  = rsp_trapped_q;
    assign rsp_data     = rsp_data_q;
`ifdef CSR_SEQ_IRQ_EN
    assign rsp_irq      = rsp_irq_q;
`endif

endmodule

// File: tb/tb_csr_sequencer.sv
// Bench for csr_sequencer: behavioural CSR unit, directed vector table, hand sequences and
// randomized requests checked against a transaction-level model. Honours CSR_SEQ_IRQ_EN.
module tb_csr_sequencer;
    import csr_pkg::*;

    typedef struct {
        logic [1:0]  kind;
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic [4:0]  cause;
        logic [31:0] exp_data;
        logic        exp_redir;
        logic        exp_trap;
        int          exp_lat;
        int          exp_ops;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_kind = '0;
    logic [1:0]  req_csr_op = '0;
    logic [11:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [31:0] req_pc = '0;
    logic [4:0]  req_cause = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_redirect;
    logic        rsp_trapped;
    logic [31:0] rsp_data;
    logic [2:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_fault;
`ifdef CSR_SEQ_IRQ_EN
    logic        irq_req = 1'b0;
    logic [31:0] irq_pc = '0;
    logic        rsp_irq;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    csr_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_kind     (req_kind),
        .req_csr_op   (req_csr_op),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_pc       (req_pc),
        .req_cause    (req_cause),
`ifdef CSR_SEQ_IRQ_EN
        .irq_req      (irq_req),
        .irq_pc       (irq_pc),
        .rsp_irq      (rsp_irq),
`endif
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_redirect (rsp_redirect),
        .rsp_trapped  (rsp_trapped),
        .rsp_data     (rsp_data),
        .csr_op       (csr_op),
        .csr_addr     (csr_addr),
        .csr_wdata    (csr_wdata),
        .csr_rdata    (csr_rdata),
        .csr_fault    (csr_fault)
    );

    // Behavioural CSR unit: one-cycle registered result, shares the reset.
    logic [31:0] u_mstatus, u_mie, u_mtvec, u_mepc, u_mcause, u_mip;
    logic [31:0] u_old, u_new;
    logic        u_hit;

    always_comb begin
        u_old = '0;
        u_hit = 1'b1;
        case (csr_addr)
            CSR_MSTATUS: u_old = u_mstatus;
            CSR_MIE:     u_old = u_mie;
            CSR_MTVEC:   u_old = u_mtvec;
            CSR_MEPC:    u_old = u_mepc;
            CSR_MCAUSE:  u_old = u_mcause;
            CSR_MIP:     u_old = u_mip;
            default:     u_hit = 1'b0;
        endcase
        case (csr_op[1:0])
            2'b01:   u_new = csr_wdata;
            2'b10:   u_new = u_old | csr_wdata;
            default: u_new = u_old & ~csr_wdata;
        endcase
    end

    always @(posedge clk) begin
        if (reset) begin
            u_mstatus <= '0; u_mie <= '0; u_mtvec <= '0;
            u_mepc <= '0; u_mcause <= '0; u_mip <= '0;
            csr_rdata <= '0;
            csr_fault <= 1'b0;
        end else begin
            csr_fault <= 1'b0;
            case (csr_op)
                CSR_OP_RW, CSR_OP_RS, CSR_OP_RC: begin
                    if (u_hit) begin
                        csr_rdata <= u_old;
                        case (csr_addr)
                            CSR_MSTATUS: u_mstatus <= u_new;
                            CSR_MIE:     u_mie     <= u_new;
                            CSR_MTVEC:   u_mtvec   <= u_new;
                            CSR_MEPC:    u_mepc    <= u_new;
                            CSR_MCAUSE:  u_mcause  <= u_new;
                            CSR_MIP:     u_mip     <= u_new;
                            default: ;
                        endcase
                    end else begin
                        csr_fault <= 1'b1;
                    end
                end
                CSR_OP_EXC: begin
                    u_mepc    <= csr_wdata;
                    u_mcause  <= {csr_addr[4], 27'd0, csr_addr[3:0]};
                    csr_rdata <= {u_mtvec[31:2], 2'b00};
                end
                CSR_OP_MRET: csr_rdata <= u_mepc;
                default: ;
            endcase
        end
    end

    // Transaction-level reference: architectural CSR contents as an associative array.
    logic [31:0] ref_csr [logic [11:0]];

    function automatic void ref_reset();
        ref_csr.delete();
        ref_csr[CSR_MSTATUS] = '0;
        ref_csr[CSR_MIE]     = '0;
        ref_csr[CSR_MTVEC]   = '0;
        ref_csr[CSR_MEPC]    = '0;
        ref_csr[CSR_MCAUSE]  = '0;
        ref_csr[CSR_MIP]     = '0;
    endfunction

    function automatic vec_t ref_predict(input vec_t v);
        vec_t        r;
        logic [31:0] old;
        bit          take_trap;
        logic [4:0]  tc;
        r = v;
        r.exp_data = '0; r.exp_redir = 1'b0; r.exp_trap = 1'b0;
        r.exp_lat = 3; r.exp_ops = 1;
        take_trap = 1'b0;
        tc = v.cause;
        if (v.kind == 2'b00) begin
            if (v.op == 2'b00) begin
                take_trap = 1'b1; tc = 5'd2; r.exp_trap = 1'b1;
            end else if (!ref_csr.exists(v.addr)) begin
                take_trap = 1'b1; tc = 5'd2; r.exp_trap = 1'b1;
                r.exp_lat = 5; r.exp_ops = 2;
            end else begin
                old = ref_csr[v.addr];
                r.exp_data = old;
                if (v.op == 2'b01)      ref_csr[v.addr] = v.wdata;
                else if (v.op == 2'b10) ref_csr[v.addr] = old | v.wdata;
                else                    ref_csr[v.addr] = old & ~v.wdata;
            end
        end else if (v.kind == 2'b01) begin
            r.exp_data  = ref_csr[CSR_MEPC];
            r.exp_redir = 1'b1;
        end else begin
            take_trap = 1'b1;
        end
        if (take_trap) begin
            ref_csr[CSR_MEPC]   = v.pc;
            ref_csr[CSR_MCAUSE] = {tc[4], 27'd0, tc[3:0]};
            r.exp_data  = ref_csr[CSR_MTVEC] & ~32'h3;
            r.exp_redir = 1'b1;
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic [1:0] kind, input logic [1:0] op, input logic [11:0] addr,
                                input logic [31:0] wdata, input logic [31:0] pc, input logic [4:0] cause,
                                input logic [31:0] data, input logic redir, input logic trap,
                                input int lat, input int ops);
        vec_t v;
        v.kind = kind; v.op = op; v.addr = addr; v.wdata = wdata; v.pc = pc; v.cause = cause;
        v.exp_data = data; v.exp_redir = redir; v.exp_trap = trap; v.exp_lat = lat; v.exp_ops = ops;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at the first negedge after the handshake edge; lat is the cycle rsp_valid shows.
    task automatic await_rsp(output int lat, output int ops);
        lat = 0;
        ops = 0;
        for (int c = 1; c <= 12; c++) begin
            if (csr_op != CSR_OP_IDLE) ops++;
            if (rsp_valid) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_req(input vec_t v, input string tag);
        int lat, ops;
        @(negedge clk);
        check({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_kind   = v.kind;
        req_csr_op = v.op;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_pc     = v.pc;
        req_cause  = v.cause;
        @(negedge clk);
        req_valid = 1'b0;
        await_rsp(lat, ops);
        check({tag, ".latency"}, lat, v.exp_lat);
        check({tag, ".op_cycles"}, ops, v.exp_ops);
        check({tag, ".data"}, rsp_data, v.exp_data);
        check({tag, ".redirect"}, {31'd0, rsp_redirect}, {31'd0, v.exp_redir});
        check({tag, ".trapped"}, {31'd0, rsp_trapped}, {31'd0, v.exp_trap});
`ifdef CSR_SEQ_IRQ_EN
        check({tag, ".irq"}, {31'd0, rsp_irq}, 32'd0);
`endif
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    localparam int NDIR = 18;

    initial begin
        vec_t dir [NDIR];
        vec_t rv;
        int   lat, ops, stable;
        bit   seen;

        dir[0]  = mk(2'b00, 2'b01, 12'h305, 32'h100, 32'h0,    5'd0,  32'h0,    1'b0, 1'b0, 3, 1);
        dir[1]  = mk(2'b10, 2'b00, 12'h0,   32'h0,   32'h40,   5'd11, 32'h100,  1'b1, 1'b0, 3, 1);
        dir[2]  = mk(2'b00, 2'b10, 12'h300, 32'h8,   32'h0,    5'd0,  32'h0,    1'b0, 1'b0, 3, 1);
        dir[3]  = mk(2'b00, 2'b10, 12'h300, 32'h0,   32'h0,    5'd0,  32'h8,    1'b0, 1'b0, 3, 1);
        dir[4]  = mk(2'b10, 2'b00, 12'h0,   32'h0,   32'h1234, 5'd11, 32'h100,  1'b1, 1'b0, 3, 1);
        dir[5]  = mk(2'b01, 2'b00, 12'h0,   32'h0,   32'h0,    5'd0,  32'h1234, 1'b1, 1'b0, 3, 1);
        dir[6]  = mk(2'b00, 2'b01, 12'h305, 32'h200, 32'h0,    5'd0,  32'h100,  1'b0, 1'b0, 3, 1);
        dir[7]  = mk(2'b00, 2'b01, 12'h7C0, 32'h55,  32'h500,  5'd0,  32'h200,  1'b1, 1'b1, 5, 2);
        dir[8]  = mk(2'b00, 2'b10, 12'h342, 32'h0,   32'h0,    5'd0,  32'h2,    1'b0, 1'b0, 3, 1);
        dir[9]  = mk(2'b00, 2'b10, 12'h341, 32'h0,   32'h0,    5'd0,  32'h500,  1'b0, 1'b0, 3, 1);
        dir[10] = mk(2'b00, 2'b00, 12'h305, 32'hFF,  32'h88,   5'd9,  32'h200,  1'b1, 1'b1, 3, 1);
        dir[11] = mk(2'b11, 2'b00, 12'h0,   32'h0,   32'h90,   5'd7,  32'h200,  1'b1, 1'b0, 3, 1);
        dir[12] = mk(2'b00, 2'b10, 12'h342, 32'h0,   32'h0,    5'd0,  32'h7,    1'b0, 1'b0, 3, 1);
        dir[13] = mk(2'b10, 2'b00, 12'h0,   32'h0,   32'h44,   5'h13, 32'h200,  1'b1, 1'b0, 3, 1);
        dir[14] = mk(2'b00, 2'b11, 12'h342, 32'h0,   32'h0,    5'd0,  32'h8000_0003, 1'b0, 1'b0, 3, 1);
        dir[15] = mk(2'b00, 2'b11, 12'h300, 32'h8,   32'h0,    5'd0,  32'h8,    1'b0, 1'b0, 3, 1);
        dir[16] = mk(2'b00, 2'b10, 12'h300, 32'h0,   32'h0,    5'd0,  32'h0,    1'b0, 1'b0, 3, 1);
        dir[17] = mk(2'b01, 2'b00, 12'h0,   32'h0,   32'h0,    5'd0,  32'h44,   1'b1, 1'b0, 3, 1);

        repeat (3) @(negedge clk);
        check("reset.req_ready", {31'd0, req_ready}, 32'd1);
        check("reset.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset.csr_op", {29'd0, csr_op}, {29'd0, 3'b100});
        check("reset.csr_addr", {20'd0, csr_addr}, 32'd0);
        check("reset.csr_wdata", csr_wdata, 32'd0);
        check("reset.rsp_data", rsp_data, 32'd0);
        check("reset.rsp_redirect", {31'd0, rsp_redirect}, 32'd0);
        check("reset.rsp_trapped", {31'd0, rsp_trapped}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < NDIR; i++) do_req(dir[i], $sformatf("dir%0d", i));

        // Backpressure: response held while a competing request sits on the input.
        @(negedge clk);
        req_valid = 1'b1; req_kind = 2'b00; req_csr_op = 2'b10;
        req_addr = CSR_MTVEC; req_wdata = 32'h0;
        @(negedge clk);
        req_valid = 1'b0;
        await_rsp(lat, ops);
        check("bp.latency", lat, 3);
        req_valid = 1'b1; req_csr_op = 2'b01; req_wdata = 32'hDEAD;
        stable = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp_valid && rsp_data == 32'h200 && !req_ready && csr_op == CSR_OP_IDLE) stable++;
        end
        check("bp.stable_cycles", stable, 10);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        do_req(mk(2'b00, 2'b10, 12'h305, 32'h0, 32'h0, 5'd0, 32'h200, 1'b0, 1'b0, 3, 1), "bp.mtvec_kept");

        // Reset while the sequencer is in WAIT.
        @(negedge clk);
        req_valid = 1'b1; req_kind = 2'b00; req_csr_op = 2'b10;
        req_addr = CSR_MSTATUS; req_wdata = 32'h8;
        @(negedge clk);
        req_valid = 1'b0;
        check("rstwait.issue_op", {29'd0, csr_op}, {29'd0, 3'b110});
        check("rstwait.issue_addr", {20'd0, csr_addr}, 32'h300);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rstwait.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rstwait.csr_op", {29'd0, csr_op}, {29'd0, 3'b100});
        check("rstwait.csr_addr", {20'd0, csr_addr}, 32'd0);
        check("rstwait.req_ready", {31'd0, req_ready}, 32'd1);
        reset = 1'b0;
        ref_reset();

        for (int i = 0; i < 150; i++) begin
            rv.kind  = 2'($urandom_range(0, 3));
            rv.op    = 2'($urandom_range(0, 3));
            rv.wdata = $urandom;
            rv.pc    = $urandom;
            rv.cause = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 7))
                0: rv.addr = CSR_MSTATUS;
                1: rv.addr = CSR_MIE;
                2: rv.addr = CSR_MTVEC;
                3: rv.addr = CSR_MEPC;
                4: rv.addr = CSR_MCAUSE;
                5: rv.addr = CSR_MIP;
                6: rv.addr = 12'h7C0;
                default: rv.addr = 12'($urandom);
            endcase
            rv = ref_predict(rv);
            do_req(rv, $sformatf("rand%0d", i));
        end

`ifdef CSR_SEQ_IRQ_EN
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // MIE clear: interrupt probed and dropped; competing request not accepted that cycle.
        irq_req = 1'b1; irq_pc = 32'h80;
        req_valid = 1'b1; req_kind = 2'b00; req_csr_op = 2'b01;
        req_addr = CSR_MTVEC; req_wdata = 32'h777;
        #1;
        check("irq.req_ready_low", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        irq_req = 1'b0;
        req_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("irq.mie0_no_rsp", {31'd0, seen}, 32'd0);
        check("irq.mie0_idle", {31'd0, req_ready}, 32'd1);

        do_req(mk(2'b00, 2'b01, 12'h305, 32'h300, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 3, 1), "irq.mtvec");
        do_req(mk(2'b00, 2'b10, 12'h300, 32'h8, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 3, 1), "irq.set_mie");

        @(negedge clk);
        irq_req = 1'b1; irq_pc = 32'h80;
        @(negedge clk);
        irq_req = 1'b0;
        await_rsp(lat, ops);
        check("irq.latency", lat, 5);
        check("irq.op_cycles", ops, 2);
        check("irq.data", rsp_data, 32'h300);
        check("irq.redirect", {31'd0, rsp_redirect}, 32'd1);
        check("irq.rsp_irq", {31'd0, rsp_irq}, 32'd1);
        check("irq.trapped", {31'd0, rsp_trapped}, 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        do_req(mk(2'b00, 2'b10, 12'h342, 32'h0, 32'h0, 5'd0, 32'h8000_000B, 1'b0, 1'b0, 3, 1), "irq.mcause");
        do_req(mk(2'b00, 2'b10, 12'h341, 32'h0, 32'h0, 5'd0, 32'h80, 1'b0, 1'b0, 3, 1), "irq.mepc");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
